// File: rtl/tt_mask_idx_rcv.sv
// Receive side of the mask/index credit interface: buffers incoming items in a
// credit-sized FIFO and unpacks them into one element per handshake for the LSU.
module tt_mask_idx_rcv #(
  parameter int unsigned VLEN         = 256,
  parameter int unsigned MASK_CREDITS = 2,
  localparam int unsigned VlW         = $clog2(VLEN + 1)
) (
  input  logic           i_clk,
  input  logic           i_reset,
  input  logic           i_mask_idx_valid,
  input  logic [64:0]    i_mask_idx_item,
  input  logic           i_mask_idx_last_idx,
  output logic           o_mask_idx_credit,
  input  logic           i_op_start,
  input  logic           i_is_indexed,
  input  logic [VlW-1:0] i_vl,
  output logic           o_elem_valid,
  input  logic           i_elem_ready,
  output logic           o_elem_mask,
  output logic [63:0]    o_elem_index,
  output logic           o_elem_last,
  output logic           o_busy,
  output logic           o_overflow_err,
  output logic           o_proto_err
);

  localparam int unsigned CntW = $clog2(MASK_CREDITS + 1);
  localparam int unsigned PtrW = (MASK_CREDITS > 1) ? $clog2(MASK_CREDITS) : 1;

  typedef enum logic {StIdle, StActive} state_e;

  state_e          state_q, state_d;
  logic            is_indexed_q, is_indexed_d;
  logic [VlW-1:0]  vl_q, vl_d;
  logic [VlW-1:0]  elem_cnt_q, elem_cnt_d;
  logic [5:0]      bitptr_q, bitptr_d;
  logic [65:0]     mem_q [MASK_CREDITS];
  logic [65:0]     mem_d [MASK_CREDITS];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            credit_q, credit_d;
  logic            overflow_q, overflow_d;
  logic            proto_q, proto_d;

  logic        empty, full, elem_valid, hs, at_last, pop, push;
  logic [65:0] head;
  logic [63:0] head_word;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(MASK_CREDITS - 1)) ? '0 : p + PtrW'(1);
  endfunction

  // Handshake, pop/push decisions and element outputs.
  always_comb begin
    empty      = (count_q == '0);
    full       = (count_q == CntW'(MASK_CREDITS));
    head       = mem_q[rd_ptr_q];
    head_word  = head[63:0];
    elem_valid = (state_q == StActive) && !empty;
    hs         = elem_valid && i_elem_ready;
    at_last    = (elem_cnt_q == (vl_q - VlW'(1)));
    // Strided words cover 64 elements; the final word may be partial.
    pop        = hs && (is_indexed_q || (bitptr_q == 6'd63) || at_last);
    // A push into a full FIFO is still taken when the head leaves this cycle.
    push       = i_mask_idx_valid && (!full || pop);

    o_elem_valid      = elem_valid;
    o_elem_mask       = elem_valid && (is_indexed_q ? head[64] : head_word[bitptr_q]);
    o_elem_index      = !elem_valid ? '0 : (is_indexed_q ? head_word : 64'(elem_cnt_q));
    o_elem_last       = elem_valid && at_last;
    o_busy            = (state_q == StActive);
    o_mask_idx_credit = credit_q;
    o_overflow_err    = overflow_q;
    o_proto_err       = proto_q;
  end

  // FIFO next state and error flags.
  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    credit_d   = pop;
    overflow_d = overflow_q | (i_mask_idx_valid && full && !pop);
    proto_d    = proto_q | (pop && (at_last != head[65]));
    if (push) begin
      mem_d[wr_ptr_q] = {i_mask_idx_last_idx, i_mask_idx_item};
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    if (push && !pop) begin
      count_d = count_q + CntW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CntW'(1);
    end
  end

  // Op sequencing: IDLE waits for a non-empty op, ACTIVE runs until element vl-1.
  always_comb begin
    state_d      = state_q;
    is_indexed_d = is_indexed_q;
    vl_d         = vl_q;
    elem_cnt_d   = elem_cnt_q;
    bitptr_d     = bitptr_q;
    unique case (state_q)
      StIdle: begin
        if (i_op_start && (i_vl != '0)) begin
          state_d      = StActive;
          is_indexed_d = i_is_indexed;
          vl_d         = i_vl;
          elem_cnt_d   = '0;
          bitptr_d     = '0;
        end
      end
      StActive: begin
        if (hs) begin
          elem_cnt_d = elem_cnt_q + VlW'(1);
          bitptr_d   = bitptr_q + 6'd1;
          if (at_last) begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Control and status registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q      <= StIdle;
      is_indexed_q <= 1'b0;
      vl_q         <= '0;
      elem_cnt_q   <= '0;
      bitptr_q     <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      credit_q     <= 1'b0;
      overflow_q   <= 1'b0;
      proto_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      is_indexed_q <= is_indexed_d;
      vl_q         <= vl_d;
      elem_cnt_q   <= elem_cnt_d;
      bitptr_q     <= bitptr_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      credit_q     <= credit_d;
      overflow_q   <= overflow_d;
      proto_q      <= proto_d;
    end
  end

  // FIFO storage; contents are don't-care while the count says empty.
  always_ff @(posedge i_clk) begin
    mem_q <= mem_d;
  end

endmodule
